// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the front end: widths, reset PC, NOP, opcodes and the fetch entry type.
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} buffer with a registered head; flush empties it in one cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot this cycle, so push-at-full is accepted alongside it.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, issues credit-limited imem requests, buffers responses, handles redirects.
// Build option FETCH_BYPASS_EN: an undropped response into an empty buffer reaches decode the same cycle.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_fet_o,
    output logic [XLEN-1:0] pc_fet_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [SW-1:0]   credit_used;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            rsp_take;
    logic            bypass;
    logic            pop;
    logic            req_fire;
    fetch_entry_t    push_entry;
    fetch_entry_t    fifo_head;

    assign rsp_take = imem_rsp_valid_i && !redirect_valid_i && (drop_cnt == '0);
`ifdef FETCH_BYPASS_EN
    assign bypass   = rsp_take && fifo_empty;
`else
    assign bypass   = 1'b0;
`endif

    assign instr_valid_o = !redirect_valid_i && (!fifo_empty || bypass);
    assign pop           = instr_valid_o && instr_ready_i;
    assign fifo_pop      = pop && !fifo_empty;
    assign fifo_push     = rsp_take && !(bypass && instr_ready_i);
    assign push_entry    = '{pc: resp_pc, instr: imem_rsp_data_i};
    assign instr_fet_o   = bypass ? imem_rsp_data_i : fifo_head.instr;
    assign pc_fet_o      = bypass ? resp_pc : fifo_head.pc;

    // Every in-flight fetch owns a buffer slot, so a response can always be pushed.
    assign credit_used      = SW'(outstanding) + SW'(fifo_count) - SW'(pop);
    assign imem_req_valid_o = rst_n_i && !redirect_valid_i && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr_o  = pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid_i) begin
            // Everything still in flight after this edge is stale and must be discarded.
            pc          <= align_pc(redirect_pc_i);
            resp_pc     <= align_pc(redirect_pc_i);
            outstanding <= outstanding - CW'(imem_rsp_valid_i);
            drop_cnt    <= outstanding - CW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) pc <= pc + XLEN'(INSTR_BYTES);
            if (rsp_take) resp_pc <= resp_pc + XLEN'(INSTR_BYTES);
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid_i),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(fifo_push && fifo_full && !fifo_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order imem model, stream scoreboard, directed corner sequences.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST = 2;
`else
    localparam int FIRST = 3;
`endif

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] target; logic [31:0] exp_pc; logic [31:0] exp_instr; } redir_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_fet_o;
    logic [31:0] pc_fet_o;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_fet_o      (instr_fet_o),
        .pc_fet_o         (pc_fet_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Environment knobs and reference model state
    mreq_t       mq[$];
    int          cyc = 0;
    int          lat_lo = 1, lat_hi = 1, req_rdy_pct = 100, dec_rdy_pct = 100;
    logic        redir = 1'b0;
    logic [31:0] redir_target = '0;
    logic [31:0] exp_fetch, exp_deliver;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_addr = '0;

    // Values sampled mid-cycle
    logic        s_reqv, s_fire, s_ival, s_deliver;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        #2;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_req_ready_i = 1'b0;
        instr_ready_i    = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;
        rst_n            = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid_o), 32'h0);
        check("rst_instr_valid", 32'(instr_valid_o), 32'h0);
        check("rst_instr", instr_fet_o, 32'h0);
        check("rst_pc", pc_fet_o, 32'h0);
        mq.delete();
        redir        = 1'b0;
        hold_pending = 1'b0;
        exp_fetch    = RPC;
        exp_deliver  = RPC;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, sample and check mid-cycle, then advance the model past the edge.
    task automatic cycle();
        logic rsp_now;
        imem_req_ready_i = (int'($urandom_range(99)) < req_rdy_pct);
        instr_ready_i    = (int'($urandom_range(99)) < dec_rdy_pct);
        redirect_valid_i = redir;
        redirect_pc_i    = redir_target;
        rsp_now          = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid_i = rsp_now;
        imem_rsp_data_i  = rsp_now ? (mq[0].addr | NOP_INSTR) : 32'h0;

        @(negedge clk);
        s_reqv    = imem_req_valid_o;
        s_fire    = imem_req_valid_o && imem_req_ready_i;
        s_addr    = imem_req_addr_o;
        s_ival    = instr_valid_o;
        s_deliver = instr_valid_o && instr_ready_i;
        s_pc      = pc_fet_o;
        s_instr   = instr_fet_o;
        if (redir) begin
            check("redir_req_valid", 32'(s_reqv), 32'h0);
            check("redir_instr_valid", 32'(s_ival), 32'h0);
        end else begin
            if (hold_pending) begin
                check("req_hold_valid", 32'(s_reqv), 32'h1);
                check("req_hold_addr", s_addr, hold_addr);
            end
            if (s_fire) check("fetch_addr", s_addr, exp_fetch);
            if (s_deliver) begin
                check("deliver_pc", s_pc, exp_deliver);
                check("deliver_instr", s_instr, exp_deliver | NOP_INSTR);
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        if (rsp_now) void'(mq.pop_front());
        if (redir) begin
            exp_fetch    = redir_target & 32'hFFFF_FFFC;
            exp_deliver  = redir_target & 32'hFFFF_FFFC;
            hold_pending = 1'b0;
        end else begin
            if (s_fire) begin
                mq.push_back('{s_addr, cyc + int'($urandom_range(lat_hi, lat_lo)) - 1});
                exp_fetch += 32'd4;
            end
            if (s_deliver) exp_deliver += 32'd4;
            hold_pending = s_reqv && !imem_req_ready_i;
            hold_addr    = s_addr;
        end
        if (mq.size() > DEPTH) check("outstanding_bound", 32'(mq.size()), 32'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        redir_vec_t vecs[4];
        logic [31:0] a0;
        int w;
        bit got_fire, got_del;

        vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0113};
        vecs[1] = '{32'h0000_2001, 32'h0000_2000, 32'h0000_2013};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
        vecs[3] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0013};

        // Reset release and back-to-back streaming
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            cycle();
            check("t1_valid", 32'(s_ival), 32'(n >= FIRST));
            if (n >= FIRST) begin
                check("t1_pc", s_pc, 32'((n - FIRST) * 4));
                check("t1_instr", s_instr, 32'((n - FIRST) * 4) | NOP_INSTR);
            end
        end

        // Decode stall: credit limit must stop requests
        dec_rdy_pct = 0;
        repeat (10) cycle();
        check("t2_req_stopped", 32'(s_reqv), 32'h0);
        dec_rdy_pct = 100;
        repeat (8) cycle();

        // Memory stall: request held with a stable address
        req_rdy_pct = 0;
        repeat (3) cycle();
        a0 = s_addr;
        check("t3_pending", 32'(s_reqv), 32'h1);
        check("t3_addr_model", a0, exp_fetch);
        for (int n = 0; n < 5; n++) begin
            cycle();
            check("t3_hold_valid", 32'(s_reqv), 32'h1);
            check("t3_hold_addr", s_addr, a0);
        end
        req_rdy_pct = 100;
        repeat (8) cycle();

        // Redirects with two fetches in flight
        lat_lo = 3;
        lat_hi = 3;
        for (int v = 0; v < 4; v++) begin
            w = 0;
            while (mq.size() != 2 && w < 20) begin
                cycle();
                w++;
            end
            check("t4_two_outstanding", 32'(mq.size()), 32'd2);
            redir        = 1'b1;
            redir_target = vecs[v].target;
            cycle();
            redir    = 1'b0;
            got_fire = 1'b0;
            got_del  = 1'b0;
            for (int n = 0; n < 30 && !got_del; n++) begin
                cycle();
                if (!got_fire && s_fire) begin
                    check("t4_next_fetch", s_addr, vecs[v].exp_pc);
                    got_fire = 1'b1;
                end
                if (s_deliver) begin
                    check("t4_next_pc", s_pc, vecs[v].exp_pc);
                    check("t4_next_instr", s_instr, vecs[v].exp_instr);
                    got_del = 1'b1;
                end
            end
            check("t4_fetch_seen", 32'(got_fire), 32'h1);
            check("t4_deliver_seen", 32'(got_del), 32'h1);
        end

        // Randomised traffic with occasional redirects, including back-to-back
        lat_lo = 1;
        lat_hi = 3;
        req_rdy_pct = 70;
        dec_rdy_pct = 70;
        for (int n = 0; n < 600; n++) begin
            redir        = (int'($urandom_range(99)) < 6);
            redir_target = $urandom;
            cycle();
        end
        redir = 1'b0;
        repeat (5) cycle();

        // Asynchronous reset mid-stream, then refetch from RESET_PC
        do_reset();
        req_rdy_pct = 100;
        dec_rdy_pct = 100;
        got_fire = 1'b0;
        for (int n = 0; n < 5 && !got_fire; n++) begin
            cycle();
            if (s_fire) begin
                check("t5_refetch_addr", s_addr, RPC);
                got_fire = 1'b1;
            end
        end
        check("t5_refetch_seen", 32'(got_fire), 32'h1);
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32I pipeline, directly upstream of the instruction decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses, buffers them in a small FIFO, and presents {pc, instr} to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered instructions and discarding in-flight stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries (>=2); also the bound on outstanding + buffered fetches.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  word-aligned fetch address
- imem_rsp_valid_i  in  1  response valid; in-order, no backpressure
- imem_rsp_data_i  in  32  fetched instruction word
- redirect_valid_i  in  1  taken branch/jump/trap redirect
- redirect_pc_i  in  32  new fetch PC
- instr_valid_o  out  1  instruction available to decode
- instr_ready_i  in  1  decode accepts instruction
- instr_fet_o  out  32  instruction word to decoder
- pc_fet_o  out  32  PC of instr_fet_o

Behaviour:
- Reset (async assert, sync release):
  - pc = resp_pc = RESET_PC.
  - outstanding = drop_cnt = fifo count = 0.
  - imem_req_valid_o = 0, instr_valid_o = 0, instr_fet_o = 0, pc_fet_o = 0.
  - Instruction memory is reset by the same rst_n_i, so no pre-reset responses arrive after release.
- Request fire (req_valid & ready):
  - imem_req_addr_o = pc.
  - pc += 4 (wraps mod 2^32).
  - outstanding += 1.
- Credit rule:
  - imem_req_valid_o = !redirect_valid_i && (outstanding + count − pop < FIFO_DEPTH).
  - pop = instr_valid_o & instr_ready_i.
  - This guarantees FIFO space for every response.
- Request hold: once imem_req_valid_o is high, it stays high with imem_req_addr_o stable until ready, unless a redirect occurs.
- Response:
  - outstanding −= 1.
  - If drop_cnt > 0: discard the response, drop_cnt −= 1.
  - Otherwise push {resp_pc, data} and resp_pc += 4.
- Simultaneous request fire and response: outstanding is unchanged.
- Output:
  - instr_valid_o = FIFO non-empty && !redirect_valid_i.
  - Head is registered; pop on handshake.
  - Simultaneous push and pop is legal at full and at empty.
- Redirect cycle, effective at the clock edge:
  - pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
  - FIFO flushed.
  - drop_cnt = outstanding − (rsp_valid ? 1 : 0). No request fires in a redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - A redirect while drop_cnt > 0 accumulates correctly via the same formula.
- Latency (non-bypass): response → instr_valid_o the next cycle.
- Throughput: 1 instruction/cycle with 1-cycle memory latency and decode always ready.
- Combinational paths: instr_ready_i and redirect_valid_i → imem_req_valid_o / instr_valid_o.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined:
  - A non-dropped response arriving while the FIFO is empty and no redirect is pending drives instr_valid_o / instr_fet_o / pc_fet_o combinationally in the same cycle.
  - If instr_ready_i is high that cycle, the response is consumed without being pushed; otherwise it is pushed.
  - The credit rule counts bypassed pops as pops.
- Undefined: always buffer; 1-cycle response-to-decode latency.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32.
  - RESET_PC default.
  - INSTR_BYTES = 4.
  - NOP encoding 32'h0000_0013.
  - The existing opcode macros.
- Sub-module fetch_fifo:
  - Synchronous FIFO of {pc, instr}, 64 bits wide, parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count.

Test Plan:
1. Reset release, RESET_PC=0, imem always ready, 1-cycle rsp, data = addr | 0x13 → first instr_valid_o 2 cycles after release with pc 0x0; then pc 0x4, 0x8, 0xC one per cycle.
2. instr_ready_i=0 for 10 cycles → outstanding + count never exceeds 2 and imem_req_valid_o drops; on release, pcs continue in order with no loss or duplication.
3. imem_req_ready_i=0 for 5 cycles with request pending → imem_req_valid_o stays 1 and imem_req_addr_o stays constant (e.g. 0x8); pc advances only on accept.
4. Two requests outstanding (0x10, 0x14), redirect_pc_i=0x102 → both responses dropped, FIFO flushed, next fetch addr 0x100, next delivered pc_fet_o = 0x100.
5. rst_n_i asserted mid-stream, asynchronously between edges → outputs go to 0 immediately; after release, refetch starts at RESET_PC.
6. With FETCH_BYPASS_EN, empty FIFO, decode ready → instr_valid_o in the same cycle as imem_rsp_valid_i, and the FIFO stays empty.
